// File: rtl/if_id_queue_pkg.sv
// Shared pipeline package: bus widths and the {pc, inst} entry payload used by
// the IF/ID queue (and intended for reuse by later inter-stage queues).
`ifndef DEFINES_SV
`include "defines.sv"
`endif

package if_id_queue_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH;
  localparam int unsigned REG_DATA_WIDTH = `REG_DATA_WIDTH;

  localparam logic [REG_DATA_WIDTH-1:0] INST_NOP = REG_DATA_WIDTH'(`INST_NOP);

  // One queued fetch result
  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] pc;
    logic [REG_DATA_WIDTH-1:0] inst;
  } pipe_entry_t;

endpackage

// File: rtl/defines.sv
// Shared pipeline macros: address/data widths and the canonical NOP word.
`ifndef DEFINES_SV
`define DEFINES_SV

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

// addi x0, x0, 0
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

`endif

// File: rtl/queue_mem.sv
// queue_mem: DEPTH x pipe_entry_t register array, one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write index
//   wdata - entry to write
//   raddr - read index
//   rdata - entry at raddr (combinational)
module queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  pipe_entry_t              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output pipe_entry_t              rdata
);

  pipe_entry_t mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read port
  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order instruction queue between IF and ID. Captures one
// {pc, inst} per cycle, presents the head show-ahead to ID, flushes on a
// taken branch and requests a PC stall while full.
// Ports:
//   clk, rst              - clock, async active-low reset
//   flush                 - discard all entries at next edge
//   if_valid/pc_if/inst_if - push side from IF
//   if_ready              - queue not full
//   id_valid/pc_id/inst_id - head entry toward ID (NOP/0 when empty)
//   id_ready              - ID consumes head this cycle
//   count                 - occupancy 0..DEPTH
//   stall_req             - queue full
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      if_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] pc_if,
  input  logic [REG_DATA_WIDTH-1:0] inst_if,
  output logic                      if_ready,
  output logic                      id_valid,
  output logic [MEM_ADDR_WIDTH-1:0] pc_id,
  output logic [REG_DATA_WIDTH-1:0] inst_id,
  input  logic                      id_ready,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      stall_req
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  pipe_entry_t wdata;
  pipe_entry_t head;

  // Status flags depend only on the occupancy register, never on inputs
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  assign push = if_valid && !full && !flush;
  assign pop  = !empty && id_ready && !flush;

  assign wdata = '{pc: pc_if, inst: inst_if};

  queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Pointer and occupancy state; flush outranks push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign count     = count_q;
  assign if_ready  = !full;
  assign stall_req = full;
  assign id_valid  = !empty;

  // Show-ahead head; stale storage is masked to 0/NOP while empty
  assign pc_id   = empty ? '0 : head.pc;
  assign inst_id = empty ? INST_NOP : head.inst;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with a reference occupancy model and a
// scoreboard queue of expected head entries.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic                      clk;
  logic                      rst;
  logic                      flush;
  logic                      if_valid;
  logic [MEM_ADDR_WIDTH-1:0] pc_if;
  logic [REG_DATA_WIDTH-1:0] inst_if;
  logic                      if_ready;
  logic                      id_valid;
  logic [MEM_ADDR_WIDTH-1:0] pc_id;
  logic [REG_DATA_WIDTH-1:0] inst_id;
  logic                      id_ready;
  logic [CW-1:0]             count;
  logic                      stall_req;

  int total = 0;
  int bad   = 0;

  pipe_entry_t sb[$];
  int          mcount = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .if_valid  (if_valid),
    .pc_if     (pc_if),
    .inst_if   (inst_if),
    .if_ready  (if_ready),
    .id_valid  (id_valid),
    .pc_id     (pc_id),
    .inst_id   (inst_id),
    .id_ready  (id_ready),
    .count     (count),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hCAFE_0000 ^ (pc << 4) ^ 32'h0000_0033;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output state implied by the model after an edge
  task automatic check_state(input string tag);
    pipe_entry_t h;
    check({tag, ".count"}, 32'(count), 32'(mcount));
    check({tag, ".id_valid"}, 32'(id_valid), 32'(mcount != 0));
    check({tag, ".if_ready"}, 32'(if_ready), 32'(mcount < DEPTH));
    check({tag, ".stall_req"}, 32'(stall_req), 32'(mcount == DEPTH));
    if (mcount != 0) begin
      h = sb[0];
      check({tag, ".pc_id"}, 32'(pc_id), 32'(h.pc));
      check({tag, ".inst_id"}, 32'(inst_id), 32'(h.inst));
    end else begin
      check({tag, ".pc_id"}, 32'(pc_id), 32'h0);
      check({tag, ".inst_id"}, 32'(inst_id), 32'h0000_0013);
    end
  endtask

  // One clock: drive, compare consumed head, clock, update model, check state
  task automatic cycle(input string tag, input logic v, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    logic m_push;
    logic m_pop;
    pipe_entry_t h;
    if_valid = v;
    pc_if    = MEM_ADDR_WIDTH'(pc);
    inst_if  = REG_DATA_WIDTH'(inst_of(pc));
    id_ready = rdy;
    flush    = fl;
    #1;
    m_push = v && (mcount < DEPTH) && !fl;
    m_pop  = rdy && (mcount > 0) && !fl;
    if (m_pop) begin
      h = sb[0];
      check({tag, ".pop_pc"}, 32'(pc_id), 32'(h.pc));
      check({tag, ".pop_inst"}, 32'(inst_id), 32'(h.inst));
    end
    @(posedge clk);
    if (fl) begin
      sb.delete();
      mcount = 0;
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_push) sb.push_back('{pc: MEM_ADDR_WIDTH'(pc), inst: REG_DATA_WIDTH'(inst_of(pc))});
      mcount = mcount + int'(m_push) - int'(m_pop);
    end
    #1;
    check_state(tag);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < DEPTH + 1 && mcount > 0; i++) cycle(tag, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; if_valid = 1'b1; pc_if = '0;
    inst_if = REG_DATA_WIDTH'(inst_of(32'h0)); id_ready = 1'b0;

    // Reset held with IF asserting valid
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");

    // Release; first edge with rst high accepts PC 0
    rst = 1'b1;
    cycle("rel", 1'b1, 32'h0, 1'b0, 1'b0);
    drain("rel_drain");

    // Fill to full, fifth push dropped, then in-order pops
    for (int i = 0; i < 5; i++) cycle("fill", 1'b1, 32'(i * 4), 1'b0, 1'b0);
    drain("fill_drain");

    // Streaming push+pop, pointers wrap
    for (int i = 0; i < 10; i++) cycle("stream", 1'b1, 32'(i * 4), 1'b1, 1'b0);
    drain("stream_drain");

    // Flush with concurrent push and pop
    for (int i = 0; i < 3; i++) cycle("pre_fl", 1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'h40, 1'b1, 1'b1);
    cycle("post_fl", 1'b1, 32'h80, 1'b0, 1'b0);
    drain("fl_drain");

    // Full with simultaneous pop: pop taken, push refused
    for (int i = 0; i < 4; i++) cycle("full", 1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    cycle("full_pop", 1'b1, 32'h300, 1'b1, 1'b0);
    drain("full_drain");

    // Asynchronous reset between edges
    cycle("ar_a", 1'b1, 32'h400, 1'b0, 1'b0);
    cycle("ar_b", 1'b1, 32'h404, 1'b0, 1'b0);
    if_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    sb.delete();
    mcount = 0;
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle("after_ar", 1'b1, 32'h500, 1'b1, 1'b0);
    drain("ar_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
